// File: rtl/reg_load_sequencer_pkg.sv
// Shared definitions for the register-load sequencer: FSM state encoding
// and the modular increment used to advance the round-robin pointer.
package reg_load_sequencer_pkg;

    // One state per Clk cycle; IDLE -> GRANT -> LOAD -> DONE -> IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // (base + offset) mod modulus, assuming base and offset are both below
    // modulus, so a single conditional subtract is enough.
    function automatic int wrap_add(input int base, input int offset, input int modulus);
        int sum;
        sum = base + offset;
        if (sum >= modulus) begin
            sum = sum - modulus;
        end
        return sum;
    endfunction

endpackage

// File: rtl/reg_load_sequencer_rr_picker.sv
// Combinational round-robin picker: first set request bit at or above the
// pointer, wrapping to bit 0 when nothing at or above the pointer is set.
module rr_picker #(
    parameter int NumReq   = 4,
    parameter int PtrWidth = 2
) (
    input  logic [NumReq-1:0]   req,
    input  logic [PtrWidth-1:0] ptr,
    output logic [NumReq-1:0]   grant,
    output logic [PtrWidth-1:0] index,
    output logic                found
);

    // Two passes: the first only considers bits at or above ptr, the second
    // catches the wrapped-around bits below ptr if the first found nothing.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (!found && req[i] && (PtrWidth'(i) >= ptr)) begin
                found    = 1'b1;
                index    = PtrWidth'(i);
                grant[i] = 1'b1;
            end
        end
        for (int i = 0; i < NumReq; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                index    = PtrWidth'(i);
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_load_sequencer.sv
// Serialises register-bank writes from NumReq requesters. A round-robin
// winner is latched in IDLE, granted, strobed into one register with an
// active-low LD, and acknowledged with a one-cycle Done pulse.
// All state changes on the falling edge of Clk; Reset is synchronous and
// active-low. Index width must satisfy 2**RegSelWidth >= NumRegs.
//
// Handshake: Req is a level sampled only in IDLE; once sampled the
// transaction always runs to completion (barring Reset). Gnt is held from
// GRANT through DONE and Done pulses for exactly the DONE cycle, so a
// requester may drop Req any time after it sees Gnt.
module reg_load_sequencer
    import reg_load_sequencer_pkg::*;
#(
    parameter int DataWidth   = 8,
    parameter int NumReq      = 4,
    parameter int NumRegs     = 8,
    parameter int RegSelWidth = 3
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [NumReq-1:0]             Req,
    input  logic [NumReq*RegSelWidth-1:0] ReqSel,
    input  logic [NumReq*DataWidth-1:0]   ReqData,
    output logic [NumReq-1:0]             Gnt,
    output logic [NumReq-1:0]             Done,
    output logic                          Err,
    output logic [NumRegs-1:0]            LD,
    output logic [DataWidth-1:0]          BusData,
    output logic                          Busy,
    output logic [1:0]                    State
);

    localparam int PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    state_t                 state;
    logic [PtrWidth-1:0]    ptr;
    logic [PtrWidth-1:0]    win_idx;
    logic [RegSelWidth-1:0] win_sel;

    logic [NumReq-1:0]      pick_grant;
    logic [PtrWidth-1:0]    pick_idx;
    logic                   pick_found;
    logic [RegSelWidth-1:0] pick_sel;
    logic [DataWidth-1:0]   pick_data;

    assign State = state;

    // Active-low strobe pattern for one register; an out-of-range index
    // matches nothing, leaving every LD bit inactive.
    function automatic logic [NumRegs-1:0] ld_strobe(input logic [RegSelWidth-1:0] sel);
        logic [NumRegs-1:0] v;
        v = '1;
        for (int r = 0; r < NumRegs; r++) begin
            if (sel == RegSelWidth'(r)) begin
                v[r] = 1'b0;
            end
        end
        return v;
    endfunction

    function automatic logic sel_valid(input logic [RegSelWidth-1:0] sel);
        return 32'(sel) < NumRegs;
    endfunction

    rr_picker #(
        .NumReq   (NumReq),
        .PtrWidth (PtrWidth)
    ) u_picker (
        .req   (Req),
        .ptr   (ptr),
        .grant (pick_grant),
        .index (pick_idx),
        .found (pick_found)
    );

    // Mux out the winner's index and data slices.
    always_comb begin
        pick_sel  = '0;
        pick_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (pick_idx == PtrWidth'(i)) begin
                pick_sel  = ReqSel[i*RegSelWidth +: RegSelWidth];
                pick_data = ReqData[i*DataWidth +: DataWidth];
            end
        end
    end

    // Transaction FSM; every output is registered and set on entry to the
    // state it belongs to.
    always_ff @(negedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            ptr     <= '0;
            win_idx <= '0;
            win_sel <= '0;
            Gnt     <= '0;
            Done    <= '0;
            Err     <= 1'b0;
            LD      <= '1;
            BusData <= '0;
            Busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state   <= GRANT;
                        win_idx <= pick_idx;
                        win_sel <= pick_sel;
                        Gnt     <= pick_grant;
                        BusData <= pick_data;
                        Busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    state <= LOAD;
                    LD    <= ld_strobe(win_sel);
                end
                LOAD: begin
                    state <= DONE;
                    LD    <= '1;
                    Done  <= Gnt;
                    Err   <= !sel_valid(win_sel);
                end
                DONE: begin
                    state   <= IDLE;
                    ptr     <= PtrWidth'(wrap_add(int'(win_idx), 1, NumReq));
                    Gnt     <= '0;
                    Done    <= '0;
                    Err     <= 1'b0;
                    BusData <= '0;
                    Busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_load_sequencer.sv
// Bench for reg_load_sequencer: directed scenarios followed by random
// traffic, all checked against a transaction-timeline model and a small
// behavioural register bank driven by LD/BusData.
module tb_reg_load_sequencer;

    localparam int NREQ  = 4;
    localparam int NREGS = 6;
    localparam int DW    = 8;
    localparam int SW    = 3;

    // ---------------- clock / reset ----------------
    bit clk;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*SW-1:0]   req_sel;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [NREGS-1:0]     ld;
    logic [DW-1:0]        bus_data;
    logic                 busy;
    logic [1:0]           dbg_state;

    reg_load_sequencer #(
        .DataWidth   (DW),
        .NumReq      (NREQ),
        .NumRegs     (NREGS),
        .RegSelWidth (SW)
    ) dut (
        .Clk     (clk),
        .Reset   (rst_n),
        .Req     (req),
        .ReqSel  (req_sel),
        .ReqData (req_data),
        .Gnt     (gnt),
        .Done    (done),
        .Err     (err),
        .LD      (ld),
        .BusData (bus_data),
        .Busy    (busy),
        .State   (dbg_state)
    );

    // Behavioural Register bank: captures DIn at a falling edge while LD is low.
    logic [DW-1:0] bank[NREGS] = '{default: '0};
    always @(negedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (ld[r] === 1'b0) bank[r] <= bus_data;
        end
    end

    // ---------------- scoreboard / model ----------------
    int n_cmp;
    int n_fail;
    logic [1:0] exp_q[$];                 // winners expected to pulse Done, in order
    logic [DW-1:0] exp_regs[NREGS] = '{default: '0};

    // Model: cycles elapsed since the current transaction was accepted
    // (0 = no transaction), plus what was latched at acceptance.
    int            m_age;
    int            m_ptr;
    int            m_win;
    int            m_sel;
    logic [DW-1:0] m_data;

    logic [NREQ-1:0]  exp_gnt;
    logic [NREQ-1:0]  exp_done;
    logic             exp_err;
    logic [NREGS-1:0] exp_ld;
    logic [DW-1:0]    exp_bus;
    logic             exp_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Predict the outputs after the coming falling edge, given current inputs.
    task automatic model_step();
        // The write lands on the edge that ends the strobe cycle, reset or not.
        if (m_age == 2 && m_sel < NREGS) exp_regs[m_sel] = m_data;
        if (!rst_n) begin
            m_age = 0;
            m_ptr = 0;
            exp_q.delete();
        end else if (m_age == 3) begin
            m_ptr = (m_win + 1) % NREQ;
            m_age = 0;
        end else if (m_age != 0) begin
            m_age++;
        end else if (req != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (req[c]) begin
                    m_win = c;
                    break;
                end
            end
            m_sel  = int'(req_sel[m_win*SW +: SW]);
            m_data = req_data[m_win*DW +: DW];
            m_age  = 1;
            exp_q.push_back(2'(m_win));
        end
        exp_gnt  = (m_age != 0) ? (4'b0001 << m_win) : 4'b0000;
        exp_busy = (m_age != 0);
        exp_bus  = (m_age != 0) ? m_data : '0;
        exp_ld   = '1;
        if (m_age == 2 && m_sel < NREGS) exp_ld[m_sel] = 1'b0;
        exp_done = (m_age == 3) ? (4'b0001 << m_win) : 4'b0000;
        exp_err  = (m_age == 3) && (m_sel >= NREGS);
    endtask

    task automatic check_outputs();
        logic [1:0] w;
        check("gnt", gnt, exp_gnt);
        check("done", done, exp_done);
        check("err", err, exp_err);
        check("ld", ld, exp_ld);
        check("bus_data", bus_data, exp_bus);
        check("busy", busy, exp_busy);
        check("state", dbg_state, m_age);
        for (int r = 0; r < NREGS; r++) begin
            check($sformatf("reg%0d", r), bank[r], exp_regs[r]);
        end
        if (done !== '0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", done, 0);
            end else begin
                w = exp_q.pop_front();
                check("sb_winner", done, 4'b0001 << w);
            end
        end
    endtask

    // ---------------- driver ----------------
    // Inputs are changed on the rising edge; the DUT acts on the falling edge.
    task automatic cycle();
        model_step();
        @(negedge clk);
        @(posedge clk);
        check_outputs();
    endtask

    task automatic set_slot(input int i, input logic [SW-1:0] sel, input logic [DW-1:0] data);
        req_sel[i*SW +: SW]  = sel;
        req_data[i*DW +: DW] = data;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int order[$];
        int times[$];
        logic [DW-1:0] old_reg;

        n_cmp    = 0;
        n_fail   = 0;
        m_age    = 0;
        m_ptr    = 0;
        m_win    = 0;
        m_sel    = 0;
        m_data   = '0;
        rst_n    = 1'b0;
        req      = '0;
        req_sel  = '0;
        req_data = '0;

        // Reset state
        cycle();
        cycle();
        check("rst_ld", ld, 6'h3f);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Single write: requester 0 -> register 5
        req = 4'b0001;
        set_slot(0, 3'd5, 8'hA5);
        cycle();
        check("t1_gnt", gnt, 4'b0001);
        req = '0;
        cycle();
        check("t1_ld", ld, 6'b011111);
        cycle();
        check("t1_done", done, 4'b0001);
        cycle();
        check("t1_reg5", bank[5], 8'hA5);

        // All requesters held: order 0,1,2,3,0 with Done every 4 cycles
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_slot(i, SW'(i + 1), DW'(8'h10 + i));
        req = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (done != '0) begin
                order.push_back($clog2(done));
                times.push_back(k);
            end
        end
        req = '0;
        check("t2_count", order.size(), 5);
        for (int k = 0; k < order.size() && k < 5; k++) begin
            check("t2_order", order[k], k % NREQ);
            if (k > 0) check("t2_gap", times[k] - times[k-1], 4);
        end

        // Pointer to 2, then requesters 0 and 1 compete
        req = 4'b0010;
        cycle();
        req = '0;
        repeat (3) cycle();
        order.delete();
        req = 4'b0011;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (done != '0) order.push_back($clog2(done));
        end
        check("t3_count", order.size(), 2);
        if (order.size() == 2) begin
            check("t3_first", order[0], 0);
            check("t3_second", order[1], 1);
        end
        req = 4'b1111;
        cycle();
        check("t3_ptr", gnt, 4'b0100);
        req = '0;
        repeat (3) cycle();

        // Out-of-range index: no strobe, Err with Done
        set_slot(1, 3'd7, 8'h77);
        req = 4'b0010;
        cycle();
        req = '0;
        cycle();
        check("t4_ld", ld, 6'h3f);
        cycle();
        check("t4_err", err, 1'b1);
        check("t4_done", done, 4'b0010);
        cycle();

        // Reset while the strobe is about to be issued
        old_reg = bank[2];
        set_slot(2, 3'd2, 8'h3C);
        req = 4'b0100;
        cycle();
        rst_n = 1'b0;
        req = '0;
        cycle();
        check("t5_ld", ld, 6'h3f);
        check("t5_busy", busy, 1'b0);
        rst_n = 1'b1;
        cycle();
        cycle();
        check("t5_reg2", bank[2], old_reg);
        req = 4'b1010;
        cycle();
        check("t5_ptr", gnt, 4'b0010);
        req = '0;
        repeat (3) cycle();

        // Req and data change after sampling
        set_slot(0, 3'd1, 8'h5A);
        req = 4'b0001;
        cycle();
        req = '0;
        set_slot(0, 3'd4, 8'hFF);
        cycle();
        cycle();
        check("t6_done", done, 4'b0001);
        cycle();
        check("t6_reg1", bank[1], 8'h5A);

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            req      = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            req_sel  = 12'($urandom);
            req_data = 32'($urandom);
            cycle();
        end

        // Drain
        rst_n = 1'b1;
        req   = '0;
        repeat (5) cycle();
        check("sb_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
